// File: rtl/fml_pkg.sv
// fml_pkg: shared FML bus constants and streamer FSM state encoding
package fml_pkg;
    localparam int         FML_BURST_LEN = 4;
    localparam int         FML_DW        = 64;
    localparam logic [7:0] FML_SEL_ALL   = 8'hff;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/fml_streamer_fifo.sv
// fml_streamer_fifo: synchronous first-word-fall-through FIFO
//   clk, rst : clock, synchronous active-high reset (flushes contents)
//   push_i   : write din_i (caller guarantees room)
//   pop_i    : consume dout_o (caller guarantees not empty)
//   dout_o   : head word, valid while empty_o is low
//   count_o  : registered occupancy
module fml_streamer_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wp_q] <= din_i;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + AW'(push_i);
            rp_q  <= rp_q + AW'(pop_i);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    assign dout_o  = mem_q[rp_q];
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
endmodule

// File: rtl/fml_streamer.sv
// fml_streamer: FML 4x64 read-only initiator streaming a memory region out as 64-bit valid/ready words
//   sys_clk, sys_rst       : clock, synchronous active-high reset
//   start, stop            : one-cycle pulses to begin / abort a transfer
//   base_adr, nbursts      : region start (32-byte units) and burst count, latched on start
//   busy, done             : transfer active / pulse on the last beat written
//   fml_*                  : FML master port (read only, 4-beat bursts)
//   s_data/s_valid/s_ready : output stream
//   FML_STREAMER_WRAP_EN   : when defined, the region is rescanned until stop
module fml_streamer import fml_pkg::*; #(
    parameter int fml_depth   = 26,
    parameter int fml_latency = 4,
    parameter int fifo_depth  = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [fml_depth-6:0] base_adr,
    input  logic [15:0]          nbursts,
    output logic                 busy,
    output logic                 done,
    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    output logic                 fml_we,
    output logic [7:0]           fml_sel,
    input  logic                 fml_eack,
    input  logic [FML_DW-1:0]    fml_di,
    output logic [FML_DW-1:0]    s_data,
    output logic                 s_valid,
    input  logic                 s_ready
);
    localparam int AW = fml_depth - 5;
    localparam int CW = $clog2(fifo_depth) + 1;
    localparam int TL = fml_latency + FML_BURST_LEN;
    state_t        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          pend_q, pend_d, zdone_q;
    logic [CW-1:0] infl_q, infl_d, occ;
    logic [TL-2:0] ack_sr_q, last_sr_q;
    logic [TL-1:0] ack_v, last_v;
    logic          ack, last, push, pop, empty, credit_ok;
`ifdef FML_STREAMER_WRAP_EN
    logic [AW-1:0] base_q;
    logic [15:0]   nb_q;
    always_ff @(posedge sys_clk) begin
        if (state_q == ST_IDLE && start) begin
            base_q <= base_adr;
            nb_q   <= nbursts;
        end
    end
`endif
    // Occupancy plus reserved beats must leave room for a whole burst.
    assign credit_ok = ({1'b0, occ} + {1'b0, infl_q}) <= (CW+1)'(fifo_depth - FML_BURST_LEN);
    // A raised strobe is held until acknowledged, even if credits drop meanwhile.
    assign fml_stb = state_q == ST_REQ && (pend_q || credit_ok);
    assign ack     = fml_stb & fml_eack;
    assign last    = ack && cnt_q == 16'd1;
    // Bit j set means an accepted burst is j cycles old; its beats land at ages latency..latency+3.
    assign ack_v   = {ack_sr_q, ack};
    assign last_v  = {last_sr_q, last};
    assign push    = |ack_v[TL-1:fml_latency];
    assign infl_d  = infl_q + (ack ? CW'(FML_BURST_LEN) : CW'(0)) - CW'(push);
    assign done    = last_v[TL-1] | zdone_q;
    assign busy    = state_q != ST_IDLE;
    assign fml_adr = {adr_q, 5'b0};
    assign fml_we  = 1'b0;
    assign fml_sel = FML_SEL_ALL;
    assign s_valid = ~empty;
    assign pop     = s_valid & s_ready;
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        pend_d  = fml_stb & ~fml_eack & ~stop;
        if (state_q == ST_IDLE && start && nbursts != 16'd0) begin
            state_d = ST_REQ;
            adr_d   = base_adr;
            cnt_d   = nbursts;
        end
        if (ack) begin
            adr_d = adr_q + AW'(1);
            cnt_d = cnt_q - 16'd1;
        end
`ifdef FML_STREAMER_WRAP_EN
        if (last) begin
            adr_d = base_q;
            cnt_d = nb_q;
        end
        if (state_q == ST_REQ && stop) state_d = ST_DRAIN;
`else
        if (state_q == ST_REQ && (stop || last)) state_d = ST_DRAIN;
`endif
        if (state_q == ST_DRAIN && infl_d == '0) state_d = ST_IDLE;
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            zdone_q   <= 1'b0;
            infl_q    <= '0;
            ack_sr_q  <= '0;
            last_sr_q <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            zdone_q   <= state_q == ST_IDLE && start && nbursts == 16'd0;
            infl_q    <= infl_d;
            ack_sr_q  <= ack_v[TL-2:0];
            last_sr_q <= last_v[TL-2:0];
        end
    end
    fml_streamer_fifo #(.W(FML_DW), .DEPTH(fifo_depth)) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .push_i  (push),
        .din_i   (fml_di),
        .pop_i   (pop),
        .dout_o  (s_data),
        .empty_o (empty),
        .count_o (occ)
    );
endmodule

// File: tb/tb_fml_streamer.sv
// tb_fml_streamer: randomized self-checking bench with an FML slave model and stream scoreboard
module tb_fml_streamer;
    localparam int L = 4, DEPTH = 16, FD = 26;
    logic          sys_clk = 1'b0, sys_rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic          fml_eack = 1'b0, s_ready = 1'b0;
    logic [FD-6:0] base_adr = '0;
    logic [15:0]   nbursts = '0;
    logic          busy, done, fml_stb, fml_we, s_valid;
    logic [FD-1:0] fml_adr;
    logic [7:0]    fml_sel;
    logic [63:0]   fml_di = '0, s_data;

    fml_streamer #(.fml_depth(FD), .fml_latency(L), .fifo_depth(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop),
        .base_adr(base_adr), .nbursts(nbursts), .busy(busy), .done(done),
        .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we), .fml_sel(fml_sel),
        .fml_eack(fml_eack), .fml_di(fml_di), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0, checks = 0, errors = 0, last_rst = 0;
    int occ = 0, pop_cnt = 0, done_cnt = 0, acks = 0;
    int cur_nb = 0, dly_min = 0, dly_max = 0, ready_mode = 0;
    int last_ack_cyc = -100, stb_rise_cyc = 0;
    logic [FD-6:0] cur_base = '0;
    logic [FD-1:0] hold_adr = '0;
    logic [63:0]   beat_at [int];
    int            push_at [int];
    int            done_at [int];
    logic [63:0]   expq [$];
    logic [FD-1:0] adr_log [$];

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // beats already accepted by the slave and not yet written into the FIFO
    function automatic int inflight(input int c);
        int n = 0;
        for (int k = c; k <= c + L + 3; k++)
            if (push_at.exists(k) && push_at[k] > last_rst) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    initial forever begin
        @(posedge sys_clk);
        #1;
        s_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
    end

    // FML slave: acks after a random delay, keeps bursts 4 cycles apart, returns 4 beats L cycles after eack
    initial begin : slave
        int  wait_left, ack_idx;
        bit  pend, prev_drop;
        logic [FD-6:0] b;
        wait_left = 0; ack_idx = 0; pend = 0; prev_drop = 1;
        forever begin
            @(posedge sys_clk);
            #2;
            fml_eack = 1'b0;
            fml_di = beat_at.exists(cyc) ? beat_at[cyc] : {$urandom, $urandom};
            if (start && !busy) ack_idx = 0;
            if (pend && !prev_drop && !sys_rst) chk("stb_hold", fml_stb == 1'b1, 64'(fml_stb), 1);
            if (!fml_stb || sys_rst) pend = 0;
            else begin
                if (!pend) begin
                    chk("credit", occ + inflight(cyc) <= DEPTH - 4, 64'(occ + inflight(cyc)), DEPTH - 4);
                    pend = 1;
                    hold_adr = fml_adr;
                    stb_rise_cyc = cyc;
                    wait_left = $urandom_range(dly_min, dly_max);
                end else chk("adr_hold", fml_adr == hold_adr, 64'(fml_adr), 64'(hold_adr));
                if (wait_left == 0 && cyc >= last_ack_cyc + 4) begin
                    fml_eack = 1'b1;
                    pend = 0;
                    b = cur_base + (FD-5)'(ack_idx);
                    chk("fml_adr", fml_adr == {b, 5'b0}, 64'(fml_adr), 64'({b, 5'b0}));
                    chk("fml_we_sel", fml_we == 1'b0 && fml_sel == 8'hff, 64'({fml_we, fml_sel}), 64'h0ff);
                    adr_log.push_back(fml_adr);
                    for (int k = 0; k < 4; k++) begin
                        beat_at[cyc + L + k] = {$urandom, $urandom};
                        push_at[cyc + L + k] = cyc;
                    end
                    ack_idx++;
                    acks++;
                    last_ack_cyc = cyc;
                    if (ack_idx == cur_nb) begin
                        done_at[cyc + L + 3] = cyc;
                        ack_idx = 0;
                    end
                end else if (wait_left > 0) wait_left--;
            end
            prev_drop = stop || sys_rst;
        end
    end

    // per-cycle comparison of stream, done and stb against the model
    initial begin : compare
        bit exp_done;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                occ = 0;
                expq.delete();
                last_rst = cyc;
            end else begin
                chk("s_valid", s_valid == (occ > 0), 64'(s_valid), 64'(occ > 0));
                if (occ > 0) chk("s_data", s_data == expq[0], s_data, expq[0]);
                exp_done = done_at.exists(cyc) && done_at[cyc] > last_rst;
                chk("done", done == exp_done, 64'(done), 64'(exp_done));
                chk("stb_busy", !fml_stb || busy, 64'(fml_stb), 64'(busy));
                if (done) done_cnt++;
                if (s_valid && s_ready && occ > 0) begin
                    occ--;
                    void'(expq.pop_front());
                    pop_cnt++;
                end
                if (push_at.exists(cyc) && push_at[cyc] > last_rst) begin
                    expq.push_back(beat_at[cyc]);
                    occ++;
                end
                chk("overflow", occ <= DEPTH, 64'(occ), DEPTH);
            end
        end
    end

    task automatic go(input logic [FD-6:0] b, input int nb);
        cur_base = b;
        cur_nb = nb;
        base_adr = b;
        nbursts = 16'(nb);
        if (nb == 0) done_at[cyc + 1] = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy || occ != 0 || inflight(cyc) != 0) && n < bound) begin
            tick();
            n++;
        end
        chk("idle_timeout", n < bound, 64'(n), 64'(bound));
    endtask

    task automatic wait_ack(input int a0);
        int n = 0;
        while (acks == a0 && n < 200) begin
            tick();
            n++;
        end
        chk("ack_seen", acks != a0, 64'(acks), 64'(a0 + 1));
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin : main
        int p0, d0, a0, l0, a, n;
        repeat (3) tick();
        sys_rst = 1'b0;
        tick();
        chk("rst_busy", busy == 1'b0, 64'(busy), 0);
        chk("rst_stb", fml_stb == 1'b0, 64'(fml_stb), 0);
        chk("rst_adr", fml_adr == '0, 64'(fml_adr), 0);
        chk("rst_valid", s_valid == 1'b0, 64'(s_valid), 0);
`ifndef FML_STREAMER_WRAP_EN
        // two bursts from 0x100, immediate acks
        ready_mode = 0; dly_min = 0; dly_max = 0;
        p0 = pop_cnt; d0 = done_cnt; l0 = adr_log.size();
        go(21'h100, 2);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("t1_done_seen", done == 1'b1, 64'(done), 1);
        tick();
        chk("t1_busy_fall", busy == 1'b0, 64'(busy), 0);
        wait_idle(200);
        chk("t1_adr0", adr_log[l0] == 26'h2000, 64'(adr_log[l0]), 64'h2000);
        chk("t1_adr1", adr_log[l0 + 1] == 26'h2020, 64'(adr_log[l0 + 1]), 64'h2020);
        chk("t1_words", pop_cnt - p0 == 8, 64'(pop_cnt - p0), 8);
        chk("t1_dones", done_cnt - d0 == 1, 64'(done_cnt - d0), 1);
        // credit limit: stalled consumer
        ready_mode = 1;
        p0 = pop_cnt; d0 = done_cnt; a0 = acks;
        go(21'h55, 8);
        repeat (60) tick();
        chk("t2_acks_stall", acks - a0 == 4, 64'(acks - a0), 4);
        chk("t2_stb_low", fml_stb == 1'b0, 64'(fml_stb), 0);
        chk("t2_valid", s_valid == 1'b1, 64'(s_valid), 1);
        ready_mode = 0;
        wait_idle(500);
        chk("t2_acks_all", acks - a0 == 8, 64'(acks - a0), 8);
        chk("t2_words", pop_cnt - p0 == 32, 64'(pop_cnt - p0), 32);
        chk("t2_dones", done_cnt - d0 == 1, 64'(done_cnt - d0), 1);
`endif
        // zero bursts
        a0 = acks;
        go(21'h7, 0);
        chk("t3_done", done == 1'b1, 64'(done), 1);
        chk("t3_busy", busy == 1'b0, 64'(busy), 0);
        tick();
        chk("t3_busy2", busy == 1'b0, 64'(busy), 0);
        chk("t3_no_req", acks == a0 && fml_stb == 1'b0, 64'(acks - a0), 0);
`ifndef FML_STREAMER_WRAP_EN
        // slow slave: 10-cycle eack delay
        ready_mode = 1; dly_min = 10; dly_max = 10;
        a0 = acks;
        go(21'h3, 1);
        wait_ack(a0);
        a = last_ack_cyc;
        chk("t4_ack_wait", a - stb_rise_cyc == 10, 64'(a - stb_rise_cyc), 10);
        while (cyc < a + L) tick();
        chk("t4_pre_beat", s_valid == 1'b0, 64'(s_valid), 0);
        tick();
        chk("t4_first_beat", s_valid == 1'b1, 64'(s_valid), 1);
        ready_mode = 0;
        wait_idle(300);
`endif
        // reset two cycles after an eack
        ready_mode = 0; dly_min = 0; dly_max = 0;
        a0 = acks;
        go(21'h40, 4);
        wait_ack(a0);
        a = last_ack_cyc;
        while (cyc < a + 2) tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("t5_busy", busy == 1'b0, 64'(busy), 0);
        chk("t5_done", done == 1'b0, 64'(done), 0);
        chk("t5_stb", fml_stb == 1'b0, 64'(fml_stb), 0);
        chk("t5_adr", fml_adr == '0, 64'(fml_adr), 0);
        for (int i = 0; i < L + 6; i++) begin
            chk("t5_late_valid", s_valid == 1'b0, 64'(s_valid), 0);
            tick();
        end
`ifdef FML_STREAMER_WRAP_EN
        // continuous scanout
        ready_mode = 0;
        p0 = pop_cnt; d0 = done_cnt; a0 = acks; l0 = adr_log.size();
        go(21'h10, 2);
        repeat (60) tick();
        chk("w_adr0", adr_log[l0] == 26'h200, 64'(adr_log[l0]), 64'h200);
        chk("w_adr1", adr_log[l0 + 1] == 26'h220, 64'(adr_log[l0 + 1]), 64'h220);
        chk("w_adr2", adr_log[l0 + 2] == 26'h200, 64'(adr_log[l0 + 2]), 64'h200);
        chk("w_adr3", adr_log[l0 + 3] == 26'h220, 64'(adr_log[l0 + 3]), 64'h220);
        chk("w_dones", done_cnt - d0 >= 2, 64'(done_cnt - d0), 2);
        pulse_stop();
        wait_idle(300);
        chk("w_busy", busy == 1'b0, 64'(busy), 0);
        chk("w_words", pop_cnt - p0 == 4 * (acks - a0), 64'(pop_cnt - p0), 64'(4 * (acks - a0)));
`endif
        // randomized transfers with random consumer, slave delay, stops and ignored starts
        for (int it = 0; it < 16; it++) begin
            ready_mode = 2;
            dly_min = 0;
            dly_max = $urandom_range(0, 3);
            go(it % 4 == 0 ? 21'h1ffffe : 21'($urandom), $urandom_range(1, 6));
            repeat ($urandom_range(1, 12)) tick();
            if (busy && $urandom_range(0, 1) == 1) begin
                base_adr = 21'($urandom);
                nbursts = 16'($urandom);
                start = 1'b1;
                tick();
                start = 1'b0;
            end
`ifdef FML_STREAMER_WRAP_EN
            repeat ($urandom_range(5, 60)) tick();
            pulse_stop();
`else
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 20)) tick();
                pulse_stop();
            end
`endif
            wait_idle(2000);
        end
        chk("end_busy", busy == 1'b0, 64'(busy), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
